// File: rtl/framer_pkg.sv
// Shared geometry, widths and FSM encoding for the playfield frame buffer path.
package framer_pkg;

  localparam int unsigned COLS    = 10;
  localparam int unsigned ROWS    = 20;
  localparam int unsigned COLOR_W = 3;
  localparam int unsigned X_W     = 4;
  localparam int unsigned Y_W     = 5;

  localparam logic [COLOR_W-1:0] COLOR_EMPTY = 3'b000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    FREEZE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant: search starts at i_ptr and wraps, first valid requester wins.
module rr_arbiter #(
  parameter int unsigned N     = 3,
  parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant_c,
  output logic [PTR_W-1:0] o_idx_c
);

  int unsigned w_pos;
  logic        w_found;

  always_comb begin
    o_grant_c = '0;
    o_idx_c   = '0;
    w_found   = 1'b0;
    w_pos     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      w_pos = 32'(i_ptr) + i;
      if (w_pos >= N) w_pos = w_pos - N;
      if (!w_found && i_req[w_pos]) begin
        w_found          = 1'b1;
        o_grant_c[w_pos] = 1'b1;
        o_idx_c          = PTR_W'(w_pos);
      end
    end
  end

endmodule

// File: rtl/frame_buffer_write_ctrl.sv
// Single write port owner for the 10x20 playfield buffer: arbitrates requester writes,
// runs the clear sweep, and blacks out writes around each vsync edge.
module frame_buffer_write_ctrl
  import framer_pkg::*;
#(
  parameter int unsigned N_REQ         = 3,
  parameter int unsigned FREEZE_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     vsync_in,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*X_W-1:0]     req_x,
  input  logic [N_REQ*Y_W-1:0]     req_y,
  input  logic [N_REQ*COLOR_W-1:0] req_color,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     clear_start,
  output logic                     clear_busy,
  output logic                     wr_en,
  output logic [X_W-1:0]           wr_x,
  output logic [Y_W-1:0]           wr_y,
  output logic [COLOR_W-1:0]       wr_color,
  output logic                     frame_commit,
  output logic                     oob_err
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned FRZ_W = $clog2(FREEZE_CYCLES + 1);

  logic               r_vs1, r_vs2, r_vs3, r_edge;
  state_t             r_state, w_state_nxt;
  logic [FRZ_W-1:0]   r_frz_cnt, w_frz_cnt_nxt;
  logic               r_clr_act, w_clr_act_nxt;
  logic [X_W-1:0]     r_cx, w_cx_nxt;
  logic [Y_W-1:0]     r_cy, w_cy_nxt;
  logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;

  logic               r_wr_en, w_wr_en_nxt;
  logic [X_W-1:0]     r_wr_x, w_wr_x_nxt;
  logic [Y_W-1:0]     r_wr_y, w_wr_y_nxt;
  logic [COLOR_W-1:0] r_wr_color, w_wr_color_nxt;
  logic               r_commit, w_commit_nxt;
  logic               r_oob, w_oob_nxt;
  logic               r_busy, w_busy_nxt;
  logic               w_sweep_issue;

  logic [N_REQ-1:0]   w_grant;
  logic [PTR_W-1:0]   w_gidx;
  logic               w_arb_en, w_xfer, w_oob;
  logic [X_W-1:0]     w_sel_x;
  logic [Y_W-1:0]     w_sel_y;
  logic [COLOR_W-1:0] w_sel_color;

  rr_arbiter #(.N(N_REQ), .PTR_W(PTR_W)) u_arb (
    .i_req     (req_valid),
    .i_ptr     (r_ptr),
    .o_grant_c (w_grant),
    .o_idx_c   (w_gidx)
  );

  // Requesters only see a grant in a plain IDLE cycle with no higher-priority event
  assign w_arb_en    = rst_n && (r_state == IDLE) && !r_edge && !clear_start;
  assign req_ready   = w_arb_en ? w_grant : '0;
  assign w_xfer      = w_arb_en && (|req_valid);
  assign w_sel_x     = req_x[32'(w_gidx)*X_W +: X_W];
  assign w_sel_y     = req_y[32'(w_gidx)*Y_W +: Y_W];
  assign w_sel_color = req_color[32'(w_gidx)*COLOR_W +: COLOR_W];
  assign w_oob       = (w_sel_x >= X_W'(COLS)) || (w_sel_y >= Y_W'(ROWS));

  always_comb begin
    w_state_nxt    = r_state;
    w_frz_cnt_nxt  = r_frz_cnt;
    w_clr_act_nxt  = r_clr_act;
    w_cx_nxt       = r_cx;
    w_cy_nxt       = r_cy;
    w_ptr_nxt      = r_ptr;
    w_wr_en_nxt    = 1'b0;
    w_wr_x_nxt     = r_wr_x;
    w_wr_y_nxt     = r_wr_y;
    w_wr_color_nxt = r_wr_color;
    w_commit_nxt   = 1'b0;
    w_oob_nxt      = r_oob;
    w_sweep_issue  = 1'b0;

    if (r_edge) begin
      w_state_nxt   = FREEZE;
      w_frz_cnt_nxt = '0;
      w_commit_nxt  = 1'b1;
      if (clear_start && !r_clr_act) begin
        w_clr_act_nxt = 1'b1;
        w_cx_nxt      = '0;
        w_cy_nxt      = '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (clear_start) begin
            w_state_nxt   = CLEAR;
            w_clr_act_nxt = 1'b1;
            w_cx_nxt      = '0;
            w_cy_nxt      = '0;
          end else if (w_xfer) begin
            w_ptr_nxt = (w_gidx == PTR_W'(N_REQ - 1)) ? '0 : PTR_W'(w_gidx + 1'b1);
            if (w_oob) begin
              w_oob_nxt = 1'b1;
            end else begin
              w_wr_en_nxt    = 1'b1;
              w_wr_x_nxt     = w_sel_x;
              w_wr_y_nxt     = w_sel_y;
              w_wr_color_nxt = w_sel_color;
            end
          end
        end
        CLEAR: begin
          w_sweep_issue  = 1'b1;
          w_wr_en_nxt    = 1'b1;
          w_wr_x_nxt     = r_cx;
          w_wr_y_nxt     = r_cy;
          w_wr_color_nxt = COLOR_EMPTY;
          if (r_cx == X_W'(COLS - 1)) begin
            w_cx_nxt = '0;
            if (r_cy == Y_W'(ROWS - 1)) begin
              w_cy_nxt      = '0;
              w_clr_act_nxt = 1'b0;
              w_state_nxt   = IDLE;
            end else begin
              w_cy_nxt = r_cy + 1'b1;
            end
          end else begin
            w_cx_nxt = r_cx + 1'b1;
          end
        end
        FREEZE: begin
          if (clear_start && !r_clr_act) begin
            w_clr_act_nxt = 1'b1;
            w_cx_nxt      = '0;
            w_cy_nxt      = '0;
          end
          if (r_frz_cnt == FRZ_W'(FREEZE_CYCLES - 1)) begin
            w_state_nxt = w_clr_act_nxt ? CLEAR : IDLE;
          end else begin
            w_frz_cnt_nxt = r_frz_cnt + 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end

    // Busy stays up through the cycle that presents the final sweep write
    w_busy_nxt = w_clr_act_nxt || w_sweep_issue;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs1      <= 1'b0;
      r_vs2      <= 1'b0;
      r_vs3      <= 1'b0;
      r_edge     <= 1'b0;
      r_state    <= IDLE;
      r_frz_cnt  <= '0;
      r_clr_act  <= 1'b0;
      r_cx       <= '0;
      r_cy       <= '0;
      r_ptr      <= '0;
      r_wr_en    <= 1'b0;
      r_wr_x     <= '0;
      r_wr_y     <= '0;
      r_wr_color <= '0;
      r_commit   <= 1'b0;
      r_oob      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_vs1      <= vsync_in;
      r_vs2      <= r_vs1;
      r_vs3      <= r_vs2;
      r_edge     <= r_vs2 && !r_vs3;
      r_state    <= w_state_nxt;
      r_frz_cnt  <= w_frz_cnt_nxt;
      r_clr_act  <= w_clr_act_nxt;
      r_cx       <= w_cx_nxt;
      r_cy       <= w_cy_nxt;
      r_ptr      <= w_ptr_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_wr_x     <= w_wr_x_nxt;
      r_wr_y     <= w_wr_y_nxt;
      r_wr_color <= w_wr_color_nxt;
      r_commit   <= w_commit_nxt;
      r_oob      <= w_oob_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign wr_en        = r_wr_en;
  assign wr_x         = r_wr_x;
  assign wr_y         = r_wr_y;
  assign wr_color     = r_wr_color;
  assign frame_commit = r_commit;
  assign oob_err      = r_oob;
  assign clear_busy   = r_busy;

endmodule

// File: tb/tb_frame_buffer_write_ctrl.sv
// Directed bench for frame_buffer_write_ctrl: arbitration, OOB, clear sweep, vsync freeze, reset.
module tb_frame_buffer_write_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vsync_in;
  logic [2:0]  req_valid;
  logic [11:0] req_x;
  logic [14:0] req_y;
  logic [8:0]  req_color;
  logic [2:0]  req_ready;
  logic        clear_start;
  logic        clear_busy;
  logic        wr_en;
  logic [3:0]  wr_x;
  logic [4:0]  wr_y;
  logic [2:0]  wr_color;
  logic        frame_commit;
  logic        oob_err;

  int checks = 0;
  int errors = 0;

  frame_buffer_write_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vsync_in     (vsync_in),
    .req_valid    (req_valid),
    .req_x        (req_x),
    .req_y        (req_y),
    .req_color    (req_color),
    .req_ready    (req_ready),
    .clear_start  (clear_start),
    .clear_busy   (clear_busy),
    .wr_en        (wr_en),
    .wr_x         (wr_x),
    .wr_y         (wr_y),
    .wr_color     (wr_color),
    .frame_commit (frame_commit),
    .oob_err      (oob_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Requester i in the standard pattern writes x=2i+1, y=2i+2, colour=i+1
  task automatic chk_req_wr(input string tag, input int i);
    chk(tag, {19'd0, wr_en, wr_x, wr_y, wr_color},
        {19'd0, 1'b1, 4'(2*i+1), 5'(2*i+2), 3'(i+1)});
  endtask

  // Follows a started sweep to completion, checking cell order, blackout and totals
  task automatic sweep_watch(input int vs_at);
    int   n, ex, ey, frz_left, commits;
    logic done;
    n = 0; ex = 0; ey = 0; frz_left = 0; commits = 0; done = 1'b0;
    for (int t = 0; t < 400 && !done; t++) begin
      cyc();
      if (frame_commit) begin
        commits++;
        frz_left = 4;
        vsync_in = 1'b0;
      end
      if (frz_left > 0) begin
        chk("freeze_wr_en", 32'(wr_en), 0);
        chk("freeze_busy", 32'(clear_busy), 1);
        frz_left--;
      end
      if (wr_en) begin
        chk("clear_cell", {19'd0, wr_x, wr_y, wr_color}, {19'd0, 4'(ex), 5'(ey), 3'd0});
        n++;
        ex++;
        if (ex == 10) begin ex = 0; ey++; end
      end
      if (n < 200) begin
        chk("clear_ready", 32'(req_ready), 0);
      end else begin
        req_valid = '0;
        cyc();
        chk("clear_busy_end", 32'(clear_busy), 0);
        chk("clear_wr_end", 32'(wr_en), 0);
        done = 1'b1;
      end
      if (vs_at >= 0 && n == vs_at && commits == 0) vsync_in = 1'b1;
    end
    chk("clear_done", 32'(done), 1);
    chk("clear_total", n, 200);
    if (vs_at >= 0) chk("commit_count", commits, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int mptr, pend;
    logic blocked;

    // Reset with requests pending: everything must read zero
    rst_n = 1'b0; vsync_in = 1'b0; clear_start = 1'b0;
    req_valid = 3'b111;
    req_x = {4'd5, 4'd3, 4'd1}; req_y = {5'd6, 5'd4, 5'd2}; req_color = {3'd3, 3'd2, 3'd1};
    repeat (2) cyc();
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_outs", {25'd0, clear_busy, wr_en, frame_commit, oob_err, wr_x == 0, wr_y == 0, wr_color == 0},
        {25'd0, 4'b0000, 3'b111});

    // Round robin with all three valid: 0,1,2,0,1,2 and writes one cycle later
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_ready", 32'(req_ready), 32'(1 << (k % 3)));
      if (k > 0) chk_req_wr("rr_wr", (k - 1) % 3);
      cyc();
    end
    req_valid = '0;
    #1;
    chk_req_wr("rr_wr_last", 2);
    cyc();
    chk("rr_idle_wr", 32'(wr_en), 0);

    // Out-of-range coordinates: handshake completes, no write, sticky error
    req_x = {4'd0, 4'd10, 4'd9}; req_y = {5'd20, 5'd3, 5'd19}; req_color = {3'd4, 3'd5, 3'd7};
    req_valid = 3'b010;
    #1;
    chk("oob_ready", 32'(req_ready), 32'b010);
    cyc();
    req_valid = 3'b001;
    #1;
    chk("oob_no_wr", 32'(wr_en), 0);
    chk("oob_flag", 32'(oob_err), 1);
    chk("oob_next_ready", 32'(req_ready), 32'b001);
    cyc();
    req_valid = 3'b100;
    #1;
    chk("oob_next_wr", {19'd0, wr_en, wr_x, wr_y, wr_color}, {19'd0, 1'b1, 4'd9, 5'd19, 3'd7});
    chk("oob_y_ready", 32'(req_ready), 32'b100);
    cyc();
    req_valid = '0;
    #1;
    chk("oob_y_no_wr", 32'(wr_en), 0);
    cyc();
    chk("oob_sticky", 32'(oob_err), 1);

    // Full clear from IDLE with requesters pushing throughout
    req_x = {4'd5, 4'd3, 4'd1}; req_y = {5'd6, 5'd4, 5'd2}; req_color = {3'd3, 3'd2, 3'd1};
    req_valid = 3'b111; clear_start = 1'b1;
    #1;
    chk("clr_start_ready", 32'(req_ready), 0);
    cyc();
    clear_start = 1'b0;
    #1;
    chk("clr_busy_on", 32'(clear_busy), 1);
    chk("clr_first_ready", 32'(req_ready), 0);
    sweep_watch(-1);

    // Vsync lands mid-sweep: blackout then resume at the next cell
    req_valid = 3'b111; clear_start = 1'b1;
    cyc();
    clear_start = 1'b0;
    sweep_watch(50);

    // Vsync edge coincides with clear_start in IDLE
    vsync_in = 1'b1;
    repeat (3) cyc();
    clear_start = 1'b1; req_valid = 3'b111;
    #1;
    chk("vc_edge_ready", 32'(req_ready), 0);
    chk("vc_edge_commit", 32'(frame_commit), 0);
    cyc();
    clear_start = 1'b0; vsync_in = 1'b0;
    chk("vc_commit", 32'(frame_commit), 1);
    chk("vc_busy", 32'(clear_busy), 1);
    chk("vc_wr", 32'(wr_en), 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("vc_freeze_wr", 32'(wr_en), 0);
      chk("vc_freeze_commit", 32'(frame_commit), 0);
      chk("vc_freeze_ready", 32'(req_ready), 0);
    end
    sweep_watch(-1);

    // Vsync during a continuous requester burst
    req_valid = 3'b111; vsync_in = 1'b1;
    mptr = 0; pend = -1;
    for (int k = 0; k < 12; k++) begin
      #1;
      blocked = (k >= 3) && (k <= 7);
      chk("burst_ready", 32'(req_ready), blocked ? 0 : 32'(1 << mptr));
      chk("burst_commit", 32'(frame_commit), 32'(k == 4));
      if (pend >= 0) chk_req_wr("burst_wr", pend);
      else chk("burst_no_wr", 32'(wr_en), 0);
      if (blocked) pend = -1;
      else begin
        pend = mptr;
        mptr = (mptr + 1) % 3;
      end
      if (k == 4) vsync_in = 1'b0;
      cyc();
    end
    req_valid = '0;
    #1;
    chk_req_wr("burst_wr_last", pend);

    // Reset in the middle of a sweep
    cyc();
    req_valid = 3'b111; clear_start = 1'b1;
    cyc();
    clear_start = 1'b0;
    repeat (5) cyc();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 0);
    chk("mid_rst_outs", {25'd0, clear_busy, wr_en, frame_commit, oob_err, wr_x == 0, wr_y == 0, wr_color == 0},
        {25'd0, 4'b0000, 3'b111});
    cyc();
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'b001);
    chk("post_rst_busy", 32'(clear_busy), 0);
    cyc();
    req_valid = '0;
    chk_req_wr("post_rst_wr", 0);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
